// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg -- definitions shared across the CPU front end.
//
// Contents:
//   RESET_PC        address the core fetches from after reset
//   NOP_INSTR       canonical RV NOP (addi x0, x0, 0), used as filler
//   ifetch_state_t  fetch sequencer states
//   fetch_pkt_t     one fetched slot: address, instruction word, misalign flag
// ----------------------------------------------------------------------------
package cpu_pkg;

   localparam logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // IDLE : issuing (or about to issue) a request for pc
   // WAIT : one request outstanding, its response still to come
   // HOLD : a fetched slot is parked because decode is stalled
   // DROP : one request outstanding whose response must be thrown away
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2,
      DROP = 2'd3
   } ifetch_state_t;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
      logic        misalign;
   } fetch_pkt_t;

endpackage

// File: rtl/ifetch.sv
// ----------------------------------------------------------------------------
// ifetch -- instruction fetch stage.
//
// Issues one instruction-memory request at a time for the address on pc,
// presents each returned word to decode through an output register, parks a
// word in a one-entry buffer while decode is stalled, and discards responses
// belonging to a fetch that was redirected (flush) or interrupted by reset.
// A misaligned pc is not sent to memory; it produces a NOP slot tagged with
// fetch_o_misalign instead.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   pc                 current fetch address from the PC register
//   fetch_i_pre_pc     pc + 4 (wraps modulo 2^64)
//   fetch_o_stall      1 = PC register must hold its value
//   flush              redirect or bubble this cycle
//   decode_stall       decode cannot accept a new slot
//   imem_req_*         request channel (valid/ready, 64-bit address)
//   imem_rsp_*         response channel, one in-order word per request
//   fetch_o_*          output register towards decode
// ----------------------------------------------------------------------------
module ifetch
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] pc,
   output logic [63:0] fetch_i_pre_pc,
   output logic        fetch_o_stall,
   input  logic        flush,
   input  logic        decode_stall,
   output logic        imem_req_valid,
   output logic [63:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        fetch_o_valid,
   output logic [63:0] fetch_o_pc,
   output logic [31:0] fetch_o_instr,
   output logic        fetch_o_misalign
);

   ifetch_state_t state, state_n;

   fetch_pkt_t out_q;      // output register contents
   logic       out_valid;
   fetch_pkt_t buf_q;      // one-entry parking buffer, meaningful in HOLD only
   logic [63:0] req_pc;    // address of the outstanding request

   logic       aligned;
   logic       cand_valid; // a slot is available for decode this cycle
   fetch_pkt_t cand_pkt;
   logic       deliver;    // slot goes to the output register at the edge
   logic       park;       // slot goes to the buffer at the edge
   logic       req_fire;

   assign aligned        = (pc[1:0] == 2'b00);
   assign fetch_i_pre_pc = pc + 64'd4;

   // -------------------------------------------------------------------------
   // State register. A reset that lands while a response is still owed sends
   // the sequencer to DROP so the stale word is swallowed after reset.
   // -------------------------------------------------------------------------
   // NOTE: every clocked process uses non-blocking assignments so all
   // registers update from the same pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         if ((state == WAIT || state == DROP) && !imem_rsp_valid)
            state <= DROP;
         else
            state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            if (park)
               state_n = HOLD;
            else if (req_fire)
               state_n = WAIT;
         end
         WAIT: begin
            // A response is consumed whatever else happens; flush only
            // matters for where the sequencer goes next.
            if (imem_rsp_valid)
               state_n = park ? HOLD : IDLE;
            else if (flush)
               state_n = DROP;
         end
         HOLD: begin
            if (flush || !decode_stall)
               state_n = IDLE;
         end
         DROP: begin
            if (imem_rsp_valid)
               state_n = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Output logic: pick the slot offered to decode this cycle, then decide
   // whether it is delivered, parked or dropped. Flush dominates stall.
   // -------------------------------------------------------------------------
   // NOTE: every variable written here gets a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      cand_valid = 1'b0;
      cand_pkt   = '{pc, NOP_INSTR, 1'b1};
      unique case (state)
         IDLE: cand_valid = !aligned;
         WAIT: begin
            cand_valid = imem_rsp_valid;
            cand_pkt   = '{req_pc, imem_rsp_data, 1'b0};
         end
         HOLD: begin
            cand_valid = 1'b1;
            cand_pkt   = buf_q;
         end
         DROP: cand_valid = 1'b0;
      endcase
   end

   assign deliver        = cand_valid && !flush && !decode_stall;
   assign park           = cand_valid && !flush &&  decode_stall;
   assign imem_req_valid = (state == IDLE) && aligned && !flush && !rst;
   assign imem_req_addr  = pc;
   assign req_fire       = imem_req_valid && imem_req_ready;
   // PC moves either to the redirect target or past a delivered slot.
   assign fetch_o_stall  = !(flush || deliver);

   // -------------------------------------------------------------------------
   // Output register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_q     <= '{RESET_PC, NOP_INSTR, 1'b0};
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (deliver) begin
         out_valid <= 1'b1;
         out_q     <= cand_pkt;
      end else if (!decode_stall) begin
         out_valid <= 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // Request address and parking buffer
   // -------------------------------------------------------------------------
   // NOTE: these are pure datapath registers qualified by the FSM state, so
   // they carry no reset; "buffer empty" is simply state != HOLD.
   always_ff @(posedge clk) begin
      if (req_fire)
         req_pc <= pc;
      if (park)
         buf_q <= cand_pkt;
   end

   assign fetch_o_valid    = out_valid;
   assign fetch_o_pc       = out_q.pc;
   assign fetch_o_instr    = out_q.instr;
   assign fetch_o_misalign = out_q.misalign;

endmodule

// File: tb/tb_ifetch.sv
// ----------------------------------------------------------------------------
// tb_ifetch -- self-checking bench for ifetch.
//
// The bench owns the PC register and a small instruction memory with a
// variable response latency. A transaction-level model (outstanding request
// flag, discard flag, parked slot, decode-facing slot) predicts every output;
// a negedge process compares the DUT against it each cycle. Directed
// scenarios with literal expectations come first, then randomized traffic.
// ----------------------------------------------------------------------------
module tb_ifetch;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst, flush, decode_stall;
   logic [63:0] pc;
   logic [63:0] fetch_i_pre_pc;
   logic        fetch_o_stall;
   logic        imem_req_valid;
   logic [63:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        fetch_o_valid;
   logic [63:0] fetch_o_pc;
   logic [31:0] fetch_o_instr;
   logic        fetch_o_misalign;

   always #5 clk = ~clk;

   ifetch dut (
      .clk              (clk),
      .rst              (rst),
      .pc               (pc),
      .fetch_i_pre_pc   (fetch_i_pre_pc),
      .fetch_o_stall    (fetch_o_stall),
      .flush            (flush),
      .decode_stall     (decode_stall),
      .imem_req_valid   (imem_req_valid),
      .imem_req_addr    (imem_req_addr),
      .imem_req_ready   (imem_req_ready),
      .imem_rsp_valid   (imem_rsp_valid),
      .imem_rsp_data    (imem_rsp_data),
      .fetch_o_valid    (fetch_o_valid),
      .fetch_o_pc       (fetch_o_pc),
      .fetch_o_instr    (fetch_o_instr),
      .fetch_o_misalign (fetch_o_misalign)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit check_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory contents: a fixed word at the reset vector, a hash elsewhere.
   function automatic logic [31:0] instr_of(input logic [63:0] a);
      if (a == 64'h0000_0000_8000_0000)
         return 32'h0050_0093;
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_5A5A;
   endfunction

   // ---------------- environment: PC register and memory ----------------
   logic [63:0] pc_reg;
   logic [63:0] redirect;
   bit          mem_pend = 1'b0;
   int          mem_cnt  = 0;
   int          mem_lat  = 1;
   logic [63:0] mem_addr;

   // ---------------- reference model ----------------
   bit          m_busy = 1'b0;      // a request is outstanding
   bit          m_discard = 1'b0;   // its response must be thrown away
   logic [63:0] m_req_addr;
   bit          m_held = 1'b0;      // a slot is parked
   logic [63:0] m_held_pc;
   logic [31:0] m_held_instr;
   bit          m_held_mis;
   bit          m_ov = 1'b0;        // decode-facing slot
   logic [63:0] m_opc;
   logic [31:0] m_oinstr;
   bit          m_omis;
   // per-cycle expectations
   bit          e_req, e_stall;
   bit          c_valid;
   logic [63:0] c_pc;
   logic [31:0] c_instr;
   bit          c_mis;

   // Apply inputs for one cycle and work out what the model expects.
   task automatic set_in(input bit r, input bit f, input bit ds, input bit rdy,
                         input logic [63:0] redir);
      bit idle;
      rst            = r;
      flush          = f;
      decode_stall   = ds;
      imem_req_ready = rdy;
      redirect       = redir;
      pc             = pc_reg;
      imem_rsp_valid = mem_pend && (mem_cnt == 0);
      imem_rsp_data  = imem_rsp_valid ? instr_of(mem_addr) : 32'($urandom);

      idle    = !m_busy && !m_held;
      c_valid = 1'b0;
      c_pc    = '0;
      c_instr = '0;
      c_mis   = 1'b0;
      if (m_held) begin
         c_valid = 1'b1; c_pc = m_held_pc; c_instr = m_held_instr; c_mis = m_held_mis;
      end else if (m_busy && imem_rsp_valid && !m_discard) begin
         c_valid = 1'b1; c_pc = m_req_addr; c_instr = instr_of(m_req_addr); c_mis = 1'b0;
      end else if (idle && pc_reg[1:0] != 2'b00) begin
         c_valid = 1'b1; c_pc = pc_reg; c_instr = 32'h0000_0013; c_mis = 1'b1;
      end
      e_req   = !r && !f && idle && (pc_reg[1:0] == 2'b00);
      e_stall = !(f || (c_valid && !ds));
      #1;
   endtask

   // Advance one clock edge: memory, model and PC register.
   task automatic step();
      bit rsp;
      @(posedge clk);
      rsp = imem_rsp_valid;
      if (rsp) mem_pend = 1'b0;
      else if (mem_pend) mem_cnt--;
      if (e_req && imem_req_ready) begin
         mem_pend = 1'b1; mem_cnt = mem_lat - 1; mem_addr = pc_reg;
      end

      if (rst) begin
         m_ov = 1'b0; m_opc = 64'h8000_0000; m_oinstr = 32'h0000_0013; m_omis = 1'b0;
         m_held = 1'b0;
         if (rsp) m_busy = 1'b0;
         m_discard = m_busy;
      end else begin
         if (flush) m_ov = 1'b0;
         else if (c_valid && !decode_stall) begin
            m_ov = 1'b1; m_opc = c_pc; m_oinstr = c_instr; m_omis = c_mis;
         end else if (!decode_stall) m_ov = 1'b0;
         m_held = c_valid && !flush && decode_stall;
         if (m_held) begin
            m_held_pc = c_pc; m_held_instr = c_instr; m_held_mis = c_mis;
         end
         if (m_busy && rsp) begin
            m_busy = 1'b0; m_discard = 1'b0;
         end else if (m_busy && flush) begin
            m_discard = 1'b1;
         end else if (e_req && imem_req_ready) begin
            m_busy = 1'b1; m_discard = 1'b0; m_req_addr = pc_reg;
         end
      end

      if (rst) pc_reg = 64'h8000_0000;
      else if (!e_stall) pc_reg = flush ? redirect : pc_reg + 64'd4;
      #1;
   endtask

   // ---------------- every-cycle comparison ----------------
   always @(negedge clk) begin
      if (check_en) begin
         check("pre_pc", fetch_i_pre_pc, pc_reg + 64'd4);
         check("req_valid", 64'(imem_req_valid), 64'(e_req));
         if (e_req) check("req_addr", imem_req_addr, pc_reg);
         check("stall", 64'(fetch_o_stall), 64'(e_stall));
         check("out_valid", 64'(fetch_o_valid), 64'(m_ov));
         if (m_ov) begin
            check("out_pc", fetch_o_pc, m_opc);
            check("out_instr", 64'(fetch_o_instr), 64'(m_oinstr));
            check("out_misalign", 64'(fetch_o_misalign), 64'(m_omis));
         end
      end
   end

   initial begin
      bit r, f, ds, rdy;
      logic [63:0] redir;
      pc_reg = 64'h8000_0000;

      // reset
      mem_lat = 1;
      set_in(1, 0, 0, 0, '0); step();
      set_in(1, 0, 0, 0, '0); step();
      check_en = 1'b1;
      check("rst_valid", 64'(fetch_o_valid), 64'd0);
      check("rst_pc", fetch_o_pc, 64'h0000_0000_8000_0000);
      check("rst_instr", 64'(fetch_o_instr), 64'h13);
      check("rst_misalign", 64'(fetch_o_misalign), 64'd0);

      // straight-line fetch with 1-cycle memory
      set_in(0, 0, 0, 1, '0);
      check("s_req_valid", 64'(imem_req_valid), 64'd1);
      check("s_req_addr", imem_req_addr, 64'h0000_0000_8000_0000);
      check("s_idle_stall", 64'(fetch_o_stall), 64'd1);
      step();
      set_in(0, 0, 0, 1, '0);
      check("s_rsp_stall", 64'(fetch_o_stall), 64'd0);
      step();
      check("s_out_valid", 64'(fetch_o_valid), 64'd1);
      check("s_out_pc", fetch_o_pc, 64'h0000_0000_8000_0000);
      check("s_out_instr", 64'(fetch_o_instr), 64'h0050_0093);

      // decode stall for three cycles around a response
      set_in(0, 0, 0, 1, '0);
      check("d_req_addr", imem_req_addr, 64'h0000_0000_8000_0004);
      step();
      for (int i = 0; i < 3; i++) begin
         set_in(0, 0, 1, 0, '0);
         check("d_hold_stall", 64'(fetch_o_stall), 64'd1);
         step();
      end
      check("d_held_not_out", 64'(fetch_o_valid), 64'd0);
      set_in(0, 0, 0, 0, '0);
      check("d_release_stall", 64'(fetch_o_stall), 64'd0);
      step();
      check("d_out_valid", 64'(fetch_o_valid), 64'd1);
      check("d_out_pc", fetch_o_pc, 64'h0000_0000_8000_0004);
      check("d_out_instr", 64'(fetch_o_instr), 64'(instr_of(64'h0000_0000_8000_0004)));

      // flush while a request is outstanding; response two cycles later
      mem_lat = 3;
      set_in(0, 0, 0, 1, '0);
      check("f_req_addr", imem_req_addr, 64'h0000_0000_8000_0008);
      step();
      set_in(0, 1, 0, 0, 64'h0000_0000_8000_1000);
      check("f_flush_stall", 64'(fetch_o_stall), 64'd0);
      step();
      for (int i = 0; i < 2; i++) begin
         set_in(0, 0, 0, 1, '0);
         check("f_drop_noreq", 64'(imem_req_valid), 64'd0);
         step();
      end
      check("f_no_valid", 64'(fetch_o_valid), 64'd0);
      set_in(0, 0, 0, 0, '0);
      check("f_redirect_req", 64'(imem_req_valid), 64'd1);
      check("f_redirect_addr", imem_req_addr, 64'h0000_0000_8000_1000);
      step();

      // misaligned pc
      set_in(0, 1, 0, 0, 64'h0000_0000_8000_0002); step();
      set_in(0, 0, 0, 0, '0);
      check("m_no_req", 64'(imem_req_valid), 64'd0);
      check("m_stall", 64'(fetch_o_stall), 64'd0);
      step();
      check("m_valid", 64'(fetch_o_valid), 64'd1);
      check("m_misalign", 64'(fetch_o_misalign), 64'd1);
      check("m_instr", 64'(fetch_o_instr), 64'h13);
      check("m_pc", fetch_o_pc, 64'h0000_0000_8000_0002);

      // reset while waiting; the stale response must stay invisible
      set_in(0, 1, 0, 0, 64'h0000_0000_8000_2000); step();
      set_in(0, 0, 0, 1, '0);
      check("r_req_addr", imem_req_addr, 64'h0000_0000_8000_2000);
      step();
      set_in(1, 1, 1, 0, 64'h0000_0000_1234_5678); step();
      check("r_valid", 64'(fetch_o_valid), 64'd0);
      check("r_pc", fetch_o_pc, 64'h0000_0000_8000_0000);
      check("r_instr", 64'(fetch_o_instr), 64'h13);
      for (int i = 0; i < 2; i++) begin
         set_in(0, 0, 0, 1, '0);
         check("r_drop_noreq", 64'(imem_req_valid), 64'd0);
         step();
      end
      check("r_stale_valid", 64'(fetch_o_valid), 64'd0);
      check("r_stale_instr", 64'(fetch_o_instr), 64'h13);

      // wrap of pc + 4
      set_in(0, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC); step();
      set_in(0, 0, 0, 0, '0);
      check("wrap_pre_pc", fetch_i_pre_pc, 64'd0);
      step();

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         mem_lat = $urandom_range(1, 3);
         r   = ($urandom_range(0, 63) == 0);
         f   = ($urandom_range(0, 7) == 0);
         ds  = ($urandom_range(0, 2) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         redir = {32'($urandom), 32'($urandom)};
         redir[1:0] = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
         if ($urandom_range(0, 15) == 0) redir = 64'hFFFF_FFFF_FFFF_FFF8;
         set_in(r, f, ds, rdy, redir);
         step();
      end

      check_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
